// File: rtl/prbs15_burst_ctrl.sv
// rtl/prbs15_burst_ctrl.sv - burst/gap sequencer driving the seed, load and freeze controls of a prbs15 generator
module prbs15_burst_ctrl #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [14:0]      seed_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic [LEN_W-1:0] gap_len_i,
  input  logic [CNT_W-1:0] num_bursts_i,
  input  logic             reseed_i,
  output logic [14:0]      lfsr_init_o,
  output logic             load_prbs_o,
  output logic             freeze_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] burst_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_GAP, S_DONE} state_t;

  state_t state_q, state_d;

  logic [14:0]      seed_q, seed_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             reseed_q, reseed_d;
  logic [LEN_W-1:0] run_cnt_q, run_cnt_d;
  logic [LEN_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic run_last, gap_last, burst_last, start_ok;

  assign run_last   = (run_cnt_q == LEN_W'(1));
  assign gap_last   = (gap_cnt_q == LEN_W'(1));
  assign burst_last = (burst_cnt_q == (num_q - CNT_W'(1)));
  assign start_ok   = (state_q == S_IDLE) && start_i && !abort_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // abort wins over every transition, including a start request in IDLE
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if ((burst_len_i == '0) || (num_bursts_i == '0)) state_d = S_DONE;
            else                                              state_d = S_LOAD;
          end
        end
        S_LOAD: state_d = S_RUN;
        S_RUN: begin
          if (run_last) begin
            if (burst_last)       state_d = S_DONE;
            else if (gap_q != '0) state_d = S_GAP;
            else if (reseed_q)    state_d = S_LOAD;
            else                  state_d = S_RUN;
          end
        end
        S_GAP: begin
          if (gap_last) state_d = reseed_q ? S_LOAD : S_RUN;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    seed_d      = seed_q;
    len_d       = len_q;
    gap_d       = gap_q;
    num_d       = num_q;
    reseed_d    = reseed_q;
    run_cnt_d   = run_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    burst_cnt_d = burst_cnt_q;

    if (start_ok) begin
      seed_d      = seed_i;
      len_d       = burst_len_i;
      gap_d       = gap_len_i;
      num_d       = num_bursts_i;
      reseed_d    = reseed_i;
      burst_cnt_d = '0;
    end

    if ((state_q == S_RUN) && run_last && !abort_i) begin
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end

    // reload on every burst start, including a seamless RUN->RUN back-to-back burst
    if ((state_d == S_RUN) && ((state_q != S_RUN) || run_last)) begin
      run_cnt_d = len_q;
    end else if (state_q == S_RUN) begin
      run_cnt_d = run_cnt_q - LEN_W'(1);
    end

    if ((state_d == S_GAP) && (state_q != S_GAP)) begin
      gap_cnt_d = gap_q;
    end else if (state_q == S_GAP) begin
      gap_cnt_d = gap_cnt_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seed_q      <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      num_q       <= '0;
      reseed_q    <= 1'b0;
      run_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      burst_cnt_q <= '0;
    end else begin
      seed_q      <= seed_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      num_q       <= num_d;
      reseed_q    <= reseed_d;
      run_cnt_q   <= run_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    load_prbs_o = 1'b0;
    freeze_o    = 1'b1;
    valid_o     = 1'b0;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (state_q)
      S_IDLE: busy_o = 1'b0;
      S_LOAD: begin
        load_prbs_o = 1'b1;
        freeze_o    = 1'b0;
      end
      S_RUN: begin
        freeze_o = 1'b0;
        valid_o  = 1'b1;
      end
      S_GAP:   freeze_o = 1'b1;
      S_DONE:  done_o   = 1'b1;
      default: busy_o   = 1'b0;
    endcase
  end

  assign lfsr_init_o = seed_q;
  assign burst_cnt_o = burst_cnt_q;

endmodule

// File: doc/prbs15_burst_ctrl.md
Name: prbs15_burst_ctrl

Overview:
- Sequencer for a prbs15 generator instance. It drives the generator's seed, load and freeze controls.
- Produces a programmed number of PRBS bursts, each of fixed length, separated by programmable idle gaps. It can optionally reseed before every burst.
- Sits between the register/config block (start/done handshake) and the prbs15 datapath. valid_o qualifies the generator's prbs_o for downstream serialiser/checker logic.

Parameters:
- LEN_W, 16, width of burst_len_i, gap_len_i and the internal run/gap counters.
- CNT_W, 8, width of num_bursts_i and burst_cnt_o.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  start request; sampled only in IDLE
- abort_i  in  1  synchronous abort; returns to IDLE
- seed_i  in  15  LFSR seed; latched at start
- burst_len_i  in  LEN_W  bits per burst; latched at start
- gap_len_i  in  LEN_W  frozen cycles between bursts; latched at start
- num_bursts_i  in  CNT_W  bursts per run; latched at start
- reseed_i  in  1  1 = reload seed before every burst; latched at start
- lfsr_init_o  out  15  to prbs15 lfsr_init_i (latched seed)
- load_prbs_o  out  1  to prbs15 load_prbs_i
- freeze_o  out  1  to prbs15 freeze_i
- valid_o  out  1  prbs_o of the generator is a payload bit this cycle
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when a run completes normally
- burst_cnt_o  out  CNT_W  bursts completed in the current/last run

Behaviour:
- States: IDLE, LOAD, RUN, GAP, DONE.
- Outputs are Moore-decoded from registered state:
  - load_prbs_o=1 only in LOAD.
  - freeze_o=1 in IDLE, GAP and DONE; freeze_o=0 in LOAD and RUN.
  - valid_o=1 only in RUN.
  - done_o=1 only in DONE.
- Reset values (async on rst_i):
  - State IDLE; all counters 0.
  - lfsr_init_o=15'h0, load_prbs_o=0, freeze_o=1, valid_o=0, busy_o=0, done_o=0, burst_cnt_o=0.
- IDLE, start_i=1 at an edge:
  - Latch all config inputs and clear burst_cnt_o.
  - If burst_len_i==0 or num_bursts_i==0, go to DONE with no LOAD. Otherwise go to LOAD.
- LOAD (exactly 1 cycle): the generator loads the seed on this edge. Go to RUN with the run counter set to the latched burst_len.
- RUN (exactly burst_len cycles):
  - First RUN cycle presents seed[14] on prbs_o; the generator shifts every RUN cycle.
  - On the last RUN cycle, burst_cnt_o increments.
  - Next state:
    - last burst -> DONE
    - else gap_len>0 -> GAP
    - else reseed -> LOAD
    - else -> RUN (seamless; valid_o stays high)
- GAP (exactly gap_len cycles, generator frozen): then LOAD if reseed, else RUN. Without reseed, the sequence continues from the frozen LFSR state.
- DONE (1 cycle): done_o pulse, then IDLE. lfsr_init_o and burst_cnt_o hold their values until the next start.
- start_i outside IDLE is ignored.
- abort_i=1 in any non-IDLE state:
  - Next state IDLE, with no done_o and no burst_cnt_o increment for a partial burst.
  - abort_i has priority over all transitions, including the last-RUN-cycle increment.
  - abort_i in IDLE has priority over start_i.
- Reset mid-run: immediate return to reset values. The prbs15 instance is not reset by this block.
- Counters: load-and-decrement, width LEN_W. No wrap; maximum burst 2^LEN_W-1 bits.

Test Plan:
- Seed 15'h6000, burst_len=4, gap=0, num_bursts=1:
  - load_prbs_o high 1 cycle after start.
  - valid_o high 4 cycles with prbs_o = 1,1,0,0.
  - done_o pulses the cycle after the last valid; burst_cnt_o=1.
- Seed 15'h6000, burst_len=2, gap=3, num_bursts=2, reseed=0:
  - Bits 1,1, then freeze_o high 3 cycles, then bits 0,0.
  - busy_o high throughout; done_o once.
- Same as the previous case but reseed=1:
  - Second burst preceded by a 1-cycle LOAD; second burst bits = 1,1.
- burst_len=3, gap=0, num_bursts=2, reseed=0: valid_o high 6 consecutive cycles with no freeze; burst_cnt_o ends at 2.
- abort_i during the 2nd RUN cycle of burst 1 (burst_len=5):
  - IDLE next cycle; freeze_o=1, valid_o=0.
  - No done_o; burst_cnt_o=0.
  - A new start is accepted the following cycle.
- num_bursts=0 and start: DONE next cycle, done_o pulse, no load_prbs_o, no valid_o.
- rst_i asserted mid-GAP: outputs return to reset values asynchronously.
